// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared constants and state type for the DSM receive path
package dsm_pkg;

  localparam int DSM_DATA_W   = 7;
  localparam int DSM_OSR_LOG2 = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dsm_dec_state_t;

endpackage

// File: rtl/dsm_window_counter.sv
// rtl/dsm_window_counter.sv - ones/sample counters and window-complete strobe
module dsm_window_counter
  import dsm_pkg::*;
#(
  parameter int OSR_LOG2 = DSM_OSR_LOG2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic              i_bit,
  output logic [OSR_LOG2:0] o_ones_total,
  output logic              o_done
);

  localparam logic [OSR_LOG2-1:0] SAMP_LAST = '1;
  localparam logic [OSR_LOG2-1:0] SAMP_ONE  = 1;

  logic [OSR_LOG2:0]   r_ones_cnt;
  logic [OSR_LOG2-1:0] r_samp_cnt;
  logic [OSR_LOG2:0]   w_bit_ext;

  assign w_bit_ext    = (OSR_LOG2+1)'(i_bit);
  // Total includes the current sample so the completing cycle sees the full count.
  assign o_ones_total = r_ones_cnt + w_bit_ext;
  assign o_done       = i_accept && (r_samp_cnt == SAMP_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ones_cnt <= '0;
      r_samp_cnt <= '0;
    end else if (i_clear || o_done) begin
      r_ones_cnt <= '0;
      r_samp_cnt <= '0;
    end else if (i_accept) begin
      r_ones_cnt <= o_ones_total;
      r_samp_cnt <= r_samp_cnt + SAMP_ONE;
    end
  end

endmodule

// File: rtl/dsm_decimator.sv
// rtl/dsm_decimator.sv - boxcar decimator/demodulator for the DSM carry bitstream
module dsm_decimator
  import dsm_pkg::*;
#(
  parameter int DATA_W   = DSM_DATA_W,
  parameter int OSR_LOG2 = DSM_OSR_LOG2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_bit_in,
  input  logic              i_bit_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_overrun
);

  localparam int SHIFT = DATA_W - OSR_LOG2;

  dsm_dec_state_t r_state;
  dsm_dec_state_t w_next_state;

  logic              w_accept;
  logic              w_clear;
  logic              w_done;
  logic [OSR_LOG2:0] w_ones_total;
  logic [DATA_W:0]   w_ext;
  logic [DATA_W:0]   w_scaled;
  logic [DATA_W-1:0] w_result;
  logic              w_load;

  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_overrun;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_clear      = 1'b1;
    case (r_state)
      IDLE: begin
        if (i_en) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        // Dropping en aborts immediately: the sample in this cycle is not taken.
        if (!i_en) begin
          w_next_state = IDLE;
        end else begin
          w_clear  = 1'b0;
          w_accept = i_bit_valid;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  dsm_window_counter #(
    .OSR_LOG2(OSR_LOG2)
  ) u_window_counter (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_clear),
    .i_accept     (w_accept),
    .i_bit        (i_bit_in),
    .o_ones_total (w_ones_total),
    .o_done       (w_done)
  );

  // A full window of ones scales to exactly 2^DATA_W, the only overflow case.
  assign w_ext    = (DATA_W+1)'(w_ones_total);
  assign w_scaled = w_ext << SHIFT;
  assign w_result = w_scaled[DATA_W] ? '1 : w_scaled[DATA_W-1:0];
  assign w_load   = w_done && (!r_out_valid || i_out_ready);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_result;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_overrun <= 1'b0;
    end else if ((r_state == IDLE) && !i_en) begin
      r_overrun <= 1'b0;
    end else if (w_done && r_out_valid && !i_out_ready) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_overrun   = r_overrun;

endmodule
